// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the TXD pin arbiter and its surroundings:
// owner request, the two UART sources, and the pin/status outputs.
interface uart_tx_arbiter_if;
  logic sel_ocd1_cpu0;
  logic uart_tx_cpu;
  logic uart_tx_ocd;
  logic TXD;
  logic owner_ocd1_cpu0;
  logic switch_busy;
  logic forced_switch;

  // Top-level side: supplies request and sources, observes the pin
  modport master (
    output sel_ocd1_cpu0,
    output uart_tx_cpu,
    output uart_tx_ocd,
    input  TXD,
    input  owner_ocd1_cpu0,
    input  switch_busy,
    input  forced_switch
  );

  // Arbiter side
  modport slave (
    input  sel_ocd1_cpu0,
    input  uart_tx_cpu,
    input  uart_tx_ocd,
    output TXD,
    output owner_ocd1_cpu0,
    output switch_busy,
    output forced_switch
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// TXD pin arbiter: shares the board TXD pin between the CPU UART and the
// OCD UART. Ownership changes only after the current source has been idle
// (mark) for IDLE_BITS bit periods, or after TIMEOUT_CYCLES in DRAIN, and
// then only after a GAP_BITS long mark gap on the pin.
module uart_tx_arbiter #(
  parameter int unsigned BAUD_PERIOD    = 868,
  parameter int unsigned IDLE_BITS      = 11,
  parameter int unsigned GAP_BITS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned BAUD_W = (BAUD_PERIOD    > 1) ? $clog2(BAUD_PERIOD)    : 1;
  localparam int unsigned IDLE_W = (IDLE_BITS      > 1) ? $clog2(IDLE_BITS)      : 1;
  localparam int unsigned GAP_W  = (GAP_BITS       > 1) ? $clog2(GAP_BITS)       : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // One bit counter serves both the idle-bit count in DRAIN and the gap-bit count in GAP
  localparam int unsigned BIT_W  = (IDLE_W > GAP_W) ? IDLE_W : GAP_W;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_PERIOD - 1);
  localparam logic [BIT_W-1:0]  IDLE_LAST = BIT_W'(IDLE_BITS - 1);
  localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'(GAP_BITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OWN,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t            state;
  logic              owner;
  logic              txd_q;
  logic              busy_q;
  logic              forced_q;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic src;
  logic req;
  logic baud_wrap;

  // Current source selection, pending-request and bit-period boundary decode
  always_comb begin
    src       = owner ? bus.uart_tx_ocd : bus.uart_tx_cpu;
    req       = (bus.sel_ocd1_cpu0 != owner);
    baud_wrap = (baud_cnt == BAUD_LAST);
  end

  // Ownership FSM with registered pin and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_OWN;
      owner    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      forced_q <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      forced_q <= 1'b0;
      case (state)
        ST_OWN: begin
          txd_q <= src;
          if (req) begin
            state    <= ST_DRAIN;
            busy_q   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
          end
        end

        ST_DRAIN: begin
          txd_q  <= src;
          to_cnt <= to_cnt + 1'b1;
          // Any space bit restarts the idle measurement
          if (!src) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
          // Exit priority: withdrawn request, then idle complete, then timeout.
          // The idle test looks at the count being completed this cycle so
          // DRAIN lasts exactly IDLE_BITS*BAUD_PERIOD cycles of mark.
          if (!req) begin
            state  <= ST_OWN;
            busy_q <= 1'b0;
          end else if (src && baud_wrap && (bit_cnt == IDLE_LAST)) begin
            state    <= ST_GAP;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            state    <= ST_GAP;
            forced_q <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_GAP: begin
          txd_q <= 1'b1;
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == GAP_LAST) begin
              bit_cnt <= '0;
              owner   <= ~owner;
              state   <= ST_OWN;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state  <= ST_OWN;
          busy_q <= 1'b0;
          txd_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.TXD             = txd_q;
  assign bus.owner_ocd1_cpu0 = owner;
  assign bus.switch_busy     = busy_q;
  assign bus.forced_switch   = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Each stimulus step is applied on
// the falling clock edge and pushes the outputs expected after the next
// rising edge; a monitor pops one entry per rising edge and compares.
module tb_uart_tx_arbiter;

  localparam int unsigned BP = 4;
  localparam int unsigned IB = 2;
  localparam int unsigned GB = 1;
  localparam int unsigned TO = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .BAUD_PERIOD   (BP),
    .IDLE_BITS     (IB),
    .GAP_BITS      (GB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic txd;
    logic own;
    logic busy;
    logic frc;
    int   sc;
    int   st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void cmp(input string name, input logic act, input logic exp,
                              input int sc, input int st);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s scen%0d step%0d: got %b expected %b", name, sc, st, act, exp);
    end
  endfunction

  // Monitor: one expected entry per rising edge, sampled 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("TXD",             bus.TXD,             e.txd,  e.sc, e.st);
        cmp("owner_ocd1_cpu0", bus.owner_ocd1_cpu0, e.own,  e.sc, e.st);
        cmp("switch_busy",     bus.switch_busy,     e.busy, e.sc, e.st);
        cmp("forced_switch",   bus.forced_switch,   e.frc,  e.sc, e.st);
      end
    end
  end

  task automatic step(input int sc, input int st, input logic rst, input logic sel,
                      input logic cpu, input logic ocd, input logic e_txd,
                      input logic e_own, input logic e_busy, input logic e_frc);
    exp_t e;
    @(negedge clk);
    reset_n           = rst;
    bus.sel_ocd1_cpu0 = sel;
    bus.uart_tx_cpu   = cpu;
    bus.uart_tx_ocd   = ocd;
    e.txd  = e_txd;
    e.own  = e_own;
    e.busy = e_busy;
    e.frc  = e_frc;
    e.sc   = sc;
    e.st   = st;
    sb.push_back(e);
  endtask

  // Two cycles in reset with a low CPU line, then one idle cycle on CPU
  task automatic do_reset(input int sc);
    step(sc, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(sc, 101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(sc, 102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:5]  c1;
    logic [0:13] c3;
    logic [0:6]  c4;
    int          w;

    bus.sel_ocd1_cpu0 = 1'b0;
    bus.uart_tx_cpu   = 1'b0;
    bus.uart_tx_ocd   = 1'b0;

    // 1: reset state, then TXD follows CPU one cycle late
    do_reset(1);
    c1 = 6'b101001;
    for (int k = 0; k < 6; k++)
      step(1, k, 1'b1, 1'b0, c1[k], ~c1[k], c1[k], 1'b0, 1'b0, 1'b0);

    // 2: clean switch to OCD with CPU idle; sel wiggle during GAP is ignored
    do_reset(2);
    for (int k = 0; k <= 12; k++)
      step(2, k, 1'b1, (k == 9 || k == 10) ? 1'b0 : 1'b1, 1'b1, 1'b0,
           1'b1, (k == 12), (k != 12), 1'b0);
    step(2, 13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2, 14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // 6: switch back toward CPU, assert reset in the middle of GAP
    for (int k = 0; k <= 9; k++)
      step(6, k, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    cmp("async_rst_TXD",   bus.TXD,             1'b1, 6, 10);
    cmp("async_rst_owner", bus.owner_ocd1_cpu0, 1'b0, 6, 10);
    cmp("async_rst_busy",  bus.switch_busy,     1'b0, 6, 10);
    cmp("async_rst_force", bus.forced_switch,   1'b0, 6, 10);

    // 3: request mid-frame; CPU keeps the line until 8 consecutive mark cycles
    do_reset(3);
    c3 = 14'b00011011111111;
    for (int k = 0; k < 14; k++)
      step(3, k, 1'b1, 1'b1, c3[k], 1'b0, c3[k], 1'b0, 1'b1, 1'b0);
    for (int k = 14; k <= 17; k++)
      step(3, k, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, (k == 17), (k != 17), 1'b0);
    step(3, 18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: request withdrawn after 3 DRAIN cycles; CPU keeps ownership, no gap
    do_reset(4);
    c4 = 7'b1101011;
    for (int k = 0; k < 7; k++)
      step(4, k, 1'b1, (k < 3) ? 1'b1 : 1'b0, c4[k], ~c4[k], c4[k], 1'b0, (k < 3), 1'b0);

    // 5: CPU stuck low; timeout after 64 DRAIN cycles forces the switch
    do_reset(5);
    for (int k = 0; k <= 69; k++)
      step(5, k, 1'b1, 1'b1, 1'b0, 1'b1, (k > 64), (k >= 68), (k < 68), (k == 64));

    w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board TXD pin between the CPU UART transmitter and the OCD (debug coprocessor) UART transmitter.
- The OCD's debug_uart_tx_sel_ocd1_cpu0 request is honoured only at a character boundary, so a frame in flight is never cut or corrupted.
- After the current source has drained, the line is held at mark for a guard gap before ownership transfers.
- Sits at top level between the MCU TXD output, the OCD TXD output and the TXD pin.

Parameters:
- BAUD_PERIOD, 868: clock cycles per UART bit; top level passes `UART_TX_BAUD_PERIOD.
- IDLE_BITS, 11: consecutive bit periods of mark on the current source that count as drained.
- GAP_BITS, 2: bit periods TXD is forced to mark between owners.
- TIMEOUT_CYCLES, 4194304: maximum cycles spent in DRAIN before a forced switch.

Ports:
- clk  input  1  system clock (PLL output).
- reset_n  input  1  asynchronous, active-low reset.
- sel_ocd1_cpu0  input  1  requested owner: 1 = OCD, 0 = CPU; driven from debug_uart_tx_sel_ocd1_cpu0.
- uart_tx_cpu  input  1  CPU UART serial output, clk domain.
- uart_tx_ocd  input  1  OCD UART serial output, clk domain.
- TXD  output  1  registered serial line to the pin.
- owner_ocd1_cpu0  output  1  current owner.
- switch_busy  output  1  high while in DRAIN or GAP.
- forced_switch  output  1  one-cycle pulse when a DRAIN ends by timeout.

Behaviour:
- Reset (asynchronous, reset_n low):
  - TXD=1 (mark), owner_ocd1_cpu0=0 (CPU), state=OWN.
  - All counters 0; switch_busy=0; forced_switch=0.
- Definitions:
  - src = owner ? uart_tx_ocd : uart_tx_cpu.
  - req = sel_ocd1_cpu0 != owner.
- States:
  - OWN:
    - TXD <= src (one clk latency from source to pin).
    - If req: go to DRAIN; clear baud_cnt, idle_bits and to_cnt.
  - DRAIN:
    - TXD <= src; the current owner keeps the line.
    - to_cnt increments every cycle.
    - If src==0: baud_cnt<=0, idle_bits<=0.
    - Else: baud_cnt increments. At baud_cnt==BAUD_PERIOD-1, baud_cnt<=0 and idle_bits++.
    - If !req (request withdrawn): back to OWN; no gap, owner unchanged.
    - Else if idle_bits reaches IDLE_BITS: go to GAP.
    - Else if to_cnt==TIMEOUT_CYCLES-1: go to GAP and pulse forced_switch for 1 cycle.
    - Priority within a cycle: withdraw > idle complete > timeout.
  - GAP:
    - TXD <= 1 for exactly GAP_BITS*BAUD_PERIOD cycles, counted with baud_cnt/bit counter.
    - sel_ocd1_cpu0 is ignored while in GAP.
    - At the end: owner <= ~owner, go to OWN.
    - If sel_ocd1_cpu0 now matches the old owner, OWN re-enters DRAIN on the next cycle; this is a normal new switch.
- switch_busy = (state != OWN), registered.
- Counter widths: $clog2 of each bound, minimum 1 bit. Counters saturate-free: every counter is cleared before it can exceed its bound.
- Forced-switch truncation: a character cut by a timeout is accepted. forced_switch exists for debug visibility.
- Inputs are already in the clk domain; no synchronizers.

Test Plan:
Common parameters: BAUD_PERIOD=4, IDLE_BITS=2, GAP_BITS=1, TIMEOUT_CYCLES=64.
1. Reset release, sel=0, uart_tx_cpu toggles 1,0,1 -> TXD=1 during reset; afterwards TXD follows uart_tx_cpu one cycle late; owner=0; switch_busy=0.
2. sel 0->1 while uart_tx_cpu idle high -> DRAIN lasts 8 cycles, then GAP holds TXD=1 for 4 cycles, then owner=1 and TXD follows uart_tx_ocd; forced_switch never pulses.
3. sel 0->1 while uart_tx_cpu is mid-frame (low) -> TXD keeps tracking CPU until 8 consecutive high cycles after the last low, then GAP, then switch; no CPU bit is lost.
4. In DRAIN, pull sel back to 0 after 3 cycles -> state returns to OWN; owner stays 0; no gap; TXD stays on CPU.
5. uart_tx_cpu held at 0, sel 0->1 -> after 64 DRAIN cycles forced_switch=1 for exactly 1 cycle, then GAP of 4 cycles, then owner=1.
6. Assert reset_n low during GAP -> TXD=1, owner=0, state=OWN immediately, without waiting for a clock edge.
